// File: rtl/inst_prefetch_if.sv
// Bus bundle between the prefetch unit, the control/decode side and the instruction ROM.
interface inst_prefetch_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic            jumpFlagIn;
    logic [XLEN-1:0] jumpAddrIn;
    logic            holdFlagIn;
    logic            romReqOut;
    logic [XLEN-1:0] romAddrOut;
    logic [XLEN-1:0] romDataIn;
    logic            instValidOut;
    logic [XLEN-1:0] instOut;
    logic [XLEN-1:0] instAddrOut;
    logic [CW-1:0]   countOut;

    // Environment side: control, decode and ROM.
    modport master (
        output jumpFlagIn, jumpAddrIn, holdFlagIn, romDataIn,
        input  romReqOut, romAddrOut, instValidOut, instOut, instAddrOut, countOut
    );

    // Prefetch unit side.
    modport slave (
        input  jumpFlagIn, jumpAddrIn, holdFlagIn, romDataIn,
        output romReqOut, romAddrOut, instValidOut, instOut, instAddrOut, countOut
    );
endinterface

// File: rtl/inst_prefetch_unit.sv
// Instruction prefetch unit: sequential fetch address generation toward a
// 1-cycle-latency ROM, a DEPTH-entry {address, instruction} FIFO toward decode,
// and a full flush plus PC redirect on jump.
module inst_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              PC_STEP  = 4
) (
    input logic            clk,
    input logic            rst,
    inst_prefetch_if.slave bus
);
    localparam int              CW      = $clog2(DEPTH + 1);
    localparam int              PW      = $clog2(DEPTH);
    localparam logic [CW:0]     DEPTH_W = (CW + 1)'(DEPTH);
    localparam logic [XLEN-1:0] STEP_W  = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_M = ~XLEN'(3);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] req_addr_q, req_addr_d;
    logic            inflight_q, inflight_d;
    logic            kill_q, kill_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [XLEN-1:0] mem_addr_q [DEPTH];
    logic [XLEN-1:0] mem_addr_d [DEPTH];
    logic [XLEN-1:0] mem_inst_q [DEPTH];
    logic [XLEN-1:0] mem_inst_d [DEPTH];

    logic            issue;
    logic            push;
    logic            pop;
    logic            head_vld;
    logic [CW:0]     occupancy;

    // Credit check uses registered state only; a pop this cycle does not free a slot early.
    assign occupancy = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
    assign head_vld  = (count_q != '0) && !bus.jumpFlagIn;
    assign issue     = !rst && !bus.jumpFlagIn && (occupancy < DEPTH_W);
    // Responses from requests made before a jump are killed, never pushed.
    assign push      = inflight_q && !kill_q && !bus.jumpFlagIn;
    assign pop       = head_vld && !bus.holdFlagIn;

    assign bus.romReqOut    = issue;
    assign bus.romAddrOut   = fetch_pc_q;
    assign bus.instValidOut = head_vld;
    assign bus.instOut      = mem_inst_q[rd_ptr_q];
    assign bus.instAddrOut  = mem_addr_q[rd_ptr_q];
    assign bus.countOut     = count_q;

    // Next-state: jump flushes everything and redirects, otherwise issue/push/pop.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_addr_d = req_addr_q;
        inflight_d = inflight_q;
        kill_d     = kill_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        mem_addr_d = mem_addr_q;
        mem_inst_d = mem_inst_q;

        if (bus.jumpFlagIn) begin
            fetch_pc_d = bus.jumpAddrIn & ALIGN_M;
            inflight_d = 1'b0;
            kill_d     = 1'b1;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end else begin
            inflight_d = issue;
            kill_d     = 1'b0;
            if (issue) begin
                fetch_pc_d = fetch_pc_q + STEP_W;
                req_addr_d = fetch_pc_q;
            end
            if (push) begin
                mem_addr_d[wr_ptr_q] = req_addr_q;
                mem_inst_d[wr_ptr_q] = bus.romDataIn;
                wr_ptr_d             = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // State register; reset also clears the FIFO storage so the head outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q <= RESET_PC;
            req_addr_q <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_addr_q[i] <= '0;
                mem_inst_q[i] <= '0;
            end
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_addr_q <= req_addr_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            mem_addr_q <= mem_addr_d;
            mem_inst_q <= mem_inst_d;
        end
    end
endmodule

// File: tb/tb_inst_prefetch_unit.sv
// Directed bench for inst_prefetch_unit: DEPTH=4 instance for the directed
// scenarios, DEPTH=8 instance for a randomized hold-pattern run.
module tb_inst_prefetch_unit;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    inst_prefetch_if #(.XLEN(32), .DEPTH(4)) bus_a ();
    inst_prefetch_if #(.XLEN(32), .DEPTH(8)) bus_b ();

    inst_prefetch_unit #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0), .PC_STEP(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    inst_prefetch_unit #(.XLEN(32), .DEPTH(8), .RESET_PC(32'h0), .PC_STEP(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC0DE_0013;
    endfunction

    // ROM model: one cycle of latency
    always @(posedge clk) begin
        bus_a.romDataIn <= rom_f(bus_a.romAddrOut);
        bus_b.romDataIn <= rom_f(bus_b.romAddrOut);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Holds rst through two edges; caller releases it.
    task automatic do_reset(input logic hold_a);
        rst = 1'b1;
        bus_a.jumpFlagIn = 1'b0;
        bus_a.jumpAddrIn = '0;
        bus_a.holdFlagIn = hold_a;
        tick();
        tick();
    endtask

    task automatic test_reset;
        bus_b.jumpFlagIn = 1'b0;
        bus_b.jumpAddrIn = '0;
        bus_b.holdFlagIn = 1'b1;
        do_reset(1'b0);
        #1;
        checks++; if (bus_a.romReqOut !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", bus_a.romReqOut); end
        checks++; if (bus_a.instValidOut !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", bus_a.instValidOut); end
        checks++; if (bus_a.countOut !== 3'd0) begin errors++; $display("FAIL rst_count got %0h exp 0", bus_a.countOut); end
        checks++; if (bus_a.instOut !== 32'h0) begin errors++; $display("FAIL rst_inst got %0h exp 0", bus_a.instOut); end
        checks++; if (bus_a.instAddrOut !== 32'h0) begin errors++; $display("FAIL rst_iaddr got %0h exp 0", bus_a.instAddrOut); end
    endtask

    task automatic test_sequential;
        tick(); rst = 1'b0; #1;
        checks++; if (bus_a.romReqOut !== 1'b1 || bus_a.romAddrOut !== 32'h0) begin errors++; $display("FAIL seq_c0_req got %0h/%0h exp 1/0", bus_a.romReqOut, bus_a.romAddrOut); end
        checks++; if (bus_a.instValidOut !== 1'b0) begin errors++; $display("FAIL seq_c0_valid got %0h exp 0", bus_a.instValidOut); end
        tick();
        checks++; if (bus_a.romReqOut !== 1'b1 || bus_a.romAddrOut !== 32'h4) begin errors++; $display("FAIL seq_c1_req got %0h/%0h exp 1/4", bus_a.romReqOut, bus_a.romAddrOut); end
        checks++; if (bus_a.instValidOut !== 1'b0) begin errors++; $display("FAIL seq_c1_valid got %0h exp 0", bus_a.instValidOut); end
        tick();
        checks++; if (bus_a.romAddrOut !== 32'h8) begin errors++; $display("FAIL seq_c2_addr got %0h exp 8", bus_a.romAddrOut); end
        checks++; if (bus_a.instValidOut !== 1'b1 || bus_a.instAddrOut !== 32'h0) begin errors++; $display("FAIL seq_c2_head got %0h/%0h exp 1/0", bus_a.instValidOut, bus_a.instAddrOut); end
        checks++; if (bus_a.instOut !== rom_f(32'h0)) begin errors++; $display("FAIL seq_c2_inst got %0h exp %0h", bus_a.instOut, rom_f(32'h0)); end
        tick();
        checks++; if (bus_a.instAddrOut !== 32'h4 || bus_a.countOut !== 3'd1) begin errors++; $display("FAIL seq_c3_head got %0h/%0h exp 4/1", bus_a.instAddrOut, bus_a.countOut); end
        tick();
        checks++; if (bus_a.instAddrOut !== 32'h8 || bus_a.instOut !== rom_f(32'h8)) begin errors++; $display("FAIL seq_c4_head got %0h/%0h exp 8/%0h", bus_a.instAddrOut, bus_a.instOut, rom_f(32'h8)); end
    endtask

    task automatic test_hold;
        int reqs;
        reqs = 0;
        do_reset(1'b1);
        tick(); rst = 1'b0; #1;
        for (int i = 0; i < 10; i++) begin
            if (i != 0) tick();
            if (bus_a.romReqOut === 1'b1) reqs++;
        end
        checks++; if (reqs != 4) begin errors++; $display("FAIL hold_reqs got %0d exp 4", reqs); end
        checks++; if (bus_a.countOut !== 3'd4 || bus_a.romReqOut !== 1'b0) begin errors++; $display("FAIL hold_full got %0h/%0h exp 4/0", bus_a.countOut, bus_a.romReqOut); end
        checks++; if (bus_a.instValidOut !== 1'b1 || bus_a.instAddrOut !== 32'h0) begin errors++; $display("FAIL hold_head got %0h/%0h exp 1/0", bus_a.instValidOut, bus_a.instAddrOut); end
        tick(); bus_a.holdFlagIn = 1'b0; #1;
        checks++; if (bus_a.romReqOut !== 1'b0 || bus_a.instAddrOut !== 32'h0) begin errors++; $display("FAIL hold_rel_c10 got %0h/%0h exp 0/0", bus_a.romReqOut, bus_a.instAddrOut); end
        tick();
        checks++; if (bus_a.romReqOut !== 1'b1 || bus_a.romAddrOut !== 32'h10) begin errors++; $display("FAIL hold_credit got %0h/%0h exp 1/10", bus_a.romReqOut, bus_a.romAddrOut); end
        checks++; if (bus_a.instAddrOut !== 32'h4 || bus_a.countOut !== 3'd3) begin errors++; $display("FAIL hold_pop got %0h/%0h exp 4/3", bus_a.instAddrOut, bus_a.countOut); end
    endtask

    task automatic test_jump_full;
        do_reset(1'b1);
        tick(); rst = 1'b0; #1;
        tick(); tick(); tick();
        @(posedge clk); #1;
        bus_a.jumpFlagIn = 1'b1; bus_a.jumpAddrIn = 32'h100; #1;
        checks++; if (bus_a.countOut !== 3'd3) begin errors++; $display("FAIL jf_pre_count got %0h exp 3", bus_a.countOut); end
        checks++; if (bus_a.instValidOut !== 1'b0 || bus_a.romReqOut !== 1'b0) begin errors++; $display("FAIL jf_t got %0h/%0h exp 0/0", bus_a.instValidOut, bus_a.romReqOut); end
        @(posedge clk); #1; bus_a.jumpFlagIn = 1'b0; #1;
        checks++; if (bus_a.countOut !== 3'd0 || bus_a.instValidOut !== 1'b0) begin errors++; $display("FAIL jf_t1_flush got %0h/%0h exp 0/0", bus_a.countOut, bus_a.instValidOut); end
        checks++; if (bus_a.romReqOut !== 1'b1 || bus_a.romAddrOut !== 32'h100) begin errors++; $display("FAIL jf_t1_req got %0h/%0h exp 1/100", bus_a.romReqOut, bus_a.romAddrOut); end
        tick();
        checks++; if (bus_a.countOut !== 3'd0 || bus_a.romAddrOut !== 32'h104) begin errors++; $display("FAIL jf_t2 got %0h/%0h exp 0/104", bus_a.countOut, bus_a.romAddrOut); end
        tick();
        checks++; if (bus_a.instValidOut !== 1'b1 || bus_a.instAddrOut !== 32'h100) begin errors++; $display("FAIL jf_t3_head got %0h/%0h exp 1/100", bus_a.instValidOut, bus_a.instAddrOut); end
        checks++; if (bus_a.instOut !== rom_f(32'h100) || bus_a.countOut !== 3'd1) begin errors++; $display("FAIL jf_t3_data got %0h/%0h exp %0h/1", bus_a.instOut, bus_a.countOut, rom_f(32'h100)); end
    endtask

    task automatic test_jump_unaligned;
        do_reset(1'b0);
        tick(); rst = 1'b0; #1;
        tick();
        @(posedge clk); #1;
        bus_a.jumpFlagIn = 1'b1; bus_a.jumpAddrIn = 32'h103; #1;
        checks++; if (bus_a.instValidOut !== 1'b0 || bus_a.romReqOut !== 1'b0) begin errors++; $display("FAIL ju_t got %0h/%0h exp 0/0", bus_a.instValidOut, bus_a.romReqOut); end
        @(posedge clk); #1; bus_a.jumpFlagIn = 1'b0; #1;
        checks++; if (bus_a.romReqOut !== 1'b1 || bus_a.romAddrOut !== 32'h100) begin errors++; $display("FAIL ju_t1_req got %0h/%0h exp 1/100", bus_a.romReqOut, bus_a.romAddrOut); end
        checks++; if (bus_a.countOut !== 3'd0) begin errors++; $display("FAIL ju_t1_count got %0h exp 0", bus_a.countOut); end
        tick();
        tick();
        checks++; if (bus_a.instValidOut !== 1'b1 || bus_a.instAddrOut !== 32'h100) begin errors++; $display("FAIL ju_t3_head got %0h/%0h exp 1/100", bus_a.instValidOut, bus_a.instAddrOut); end
    endtask

    task automatic test_back_to_back_jumps;
        do_reset(1'b0);
        tick(); rst = 1'b0; #1;
        @(posedge clk); #1;
        bus_a.jumpFlagIn = 1'b1; bus_a.jumpAddrIn = 32'h200; #1;
        checks++; if (bus_a.romReqOut !== 1'b0) begin errors++; $display("FAIL bb_t_req got %0h exp 0", bus_a.romReqOut); end
        @(posedge clk); #1; bus_a.jumpAddrIn = 32'h300; #1;
        checks++; if (bus_a.romReqOut !== 1'b0 || bus_a.instValidOut !== 1'b0) begin errors++; $display("FAIL bb_t1 got %0h/%0h exp 0/0", bus_a.romReqOut, bus_a.instValidOut); end
        @(posedge clk); #1; bus_a.jumpFlagIn = 1'b0; #1;
        checks++; if (bus_a.romReqOut !== 1'b1 || bus_a.romAddrOut !== 32'h300) begin errors++; $display("FAIL bb_t2_req got %0h/%0h exp 1/300", bus_a.romReqOut, bus_a.romAddrOut); end
        checks++; if (bus_a.countOut !== 3'd0) begin errors++; $display("FAIL bb_t2_count got %0h exp 0", bus_a.countOut); end
        tick();
        checks++; if (bus_a.instValidOut !== 1'b0 || bus_a.romAddrOut !== 32'h304) begin errors++; $display("FAIL bb_t3 got %0h/%0h exp 0/304", bus_a.instValidOut, bus_a.romAddrOut); end
        tick();
        checks++; if (bus_a.instValidOut !== 1'b1 || bus_a.instAddrOut !== 32'h300) begin errors++; $display("FAIL bb_t4_head got %0h/%0h exp 1/300", bus_a.instValidOut, bus_a.instAddrOut); end
        tick();
        checks++; if (bus_a.instAddrOut !== 32'h304) begin errors++; $display("FAIL bb_t5_head got %0h exp 304", bus_a.instAddrOut); end
    endtask

    task automatic test_reset_midstream;
        do_reset(1'b0);
        tick(); rst = 1'b0; #1;
        tick();
        tick();
        checks++; if (bus_a.instValidOut !== 1'b1 || bus_a.instAddrOut !== 32'h0) begin errors++; $display("FAIL rm_c2_head got %0h/%0h exp 1/0", bus_a.instValidOut, bus_a.instAddrOut); end
        @(posedge clk); #1; rst = 1'b1; #1;
        checks++; if (bus_a.romReqOut !== 1'b0) begin errors++; $display("FAIL rm_c3_req got %0h exp 0", bus_a.romReqOut); end
        tick();
        checks++; if (bus_a.instValidOut !== 1'b0 || bus_a.countOut !== 3'd0) begin errors++; $display("FAIL rm_c4_state got %0h/%0h exp 0/0", bus_a.instValidOut, bus_a.countOut); end
        checks++; if (bus_a.instOut !== 32'h0 || bus_a.instAddrOut !== 32'h0 || bus_a.romReqOut !== 1'b0) begin errors++; $display("FAIL rm_c4_out got %0h/%0h/%0h exp 0/0/0", bus_a.instOut, bus_a.instAddrOut, bus_a.romReqOut); end
        @(posedge clk); #1; rst = 1'b0; #1;
        checks++; if (bus_a.romReqOut !== 1'b1 || bus_a.romAddrOut !== 32'h0) begin errors++; $display("FAIL rm_c5_req got %0h/%0h exp 1/0", bus_a.romReqOut, bus_a.romAddrOut); end
        tick();
        checks++; if (bus_a.countOut !== 3'd0 || bus_a.instValidOut !== 1'b0) begin errors++; $display("FAIL rm_c6_nostale got %0h/%0h exp 0/0", bus_a.countOut, bus_a.instValidOut); end
        tick();
        checks++; if (bus_a.instAddrOut !== 32'h0 || bus_a.instOut !== rom_f(32'h0)) begin errors++; $display("FAIL rm_c7_head got %0h/%0h exp 0/%0h", bus_a.instAddrOut, bus_a.instOut, rom_f(32'h0)); end
    endtask

    task automatic test_random_depth8;
        logic [31:0] exp_req;
        logic [31:0] exp_pop;
        int          pops;
        exp_req = 32'h0;
        exp_pop = 32'h0;
        pops    = 0;
        bus_b.holdFlagIn = 1'b1;
        do_reset(1'b1);
        tick(); rst = 1'b0; bus_b.holdFlagIn = 1'($urandom_range(0, 1)); #1;
        for (int i = 0; i < 200; i++) begin
            checks++; if (bus_b.countOut > 4'd8) begin errors++; $display("FAIL rnd_count got %0d exp <=8", bus_b.countOut); end
            if (bus_b.romReqOut === 1'b1) begin
                checks++; if (bus_b.romAddrOut !== exp_req) begin errors++; $display("FAIL rnd_req got %0h exp %0h", bus_b.romAddrOut, exp_req); end
                exp_req = exp_req + 32'h4;
            end
            if (bus_b.instValidOut === 1'b1 && bus_b.holdFlagIn === 1'b0) begin
                checks++; if (bus_b.instAddrOut !== exp_pop || bus_b.instOut !== rom_f(exp_pop)) begin errors++; $display("FAIL rnd_pop got %0h/%0h exp %0h/%0h", bus_b.instAddrOut, bus_b.instOut, exp_pop, rom_f(exp_pop)); end
                exp_pop = exp_pop + 32'h4;
                pops++;
            end
            @(posedge clk); #1;
            if (i < 60)       bus_b.holdFlagIn = 1'($urandom_range(0, 1));
            else if (i < 90)  bus_b.holdFlagIn = 1'b1;
            else              bus_b.holdFlagIn = ($urandom_range(0, 3) == 0);
            #1;
        end
        checks++; if (pops < 20) begin errors++; $display("FAIL rnd_progress got %0d exp >=20", pops); end
        checks++; if ((exp_req - exp_pop) > 32'd32) begin errors++; $display("FAIL rnd_outstanding got %0h exp <=20", exp_req - exp_pop); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_sequential();
        test_hold();
        test_jump_full();
        test_jump_unaligned();
        test_back_to_back_jumps();
        test_reset_midstream();
        test_random_depth8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
